// File: rtl/lfsr_prbs_gen_pkg.sv
// Shared constants for the LFSR/PRBS generator: legal width range,
// FSM state encoding and the per-width feedback tap table.
package lfsr_pkg;

  localparam int LFSR_MIN_N = 3;
  localparam int LFSR_MAX_N = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  // Tap mask: register bit k (numbered N..1) maps to mask index k-1.
  // Upper bits beyond N are zero, so callers keep only [N-1:0].
  function automatic logic [15:0] lfsr_taps(input int n);
    logic [15:0] mask;
    case (n)
      3:       mask = 16'h0006;
      4:       mask = 16'h000C;
      5:       mask = 16'h0014;
      6:       mask = 16'h0030;
      7:       mask = 16'h0060;
      8:       mask = 16'h00B8;
      9:       mask = 16'h0110;
      10:      mask = 16'h0240;
      11:      mask = 16'h0500;
      12:      mask = 16'h0829;
      13:      mask = 16'h100D;
      14:      mask = 16'h2015;
      15:      mask = 16'h6000;
      16:      mask = 16'hD008;
      default: mask = 16'h0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_prbs_gen_if.sv
// Seed handshake and sequence output bundle for lfsr_prbs_gen.
// master drives enable/seed, slave is the generator.
interface lfsr_prbs_gen_if #(parameter int N = 8);

  logic         i_ena;
  logic [N-1:0] i_seed_din;
  logic         i_seed_valid;
  logic         o_seed_ready;
  logic [N-1:0] o_lfsr_dout;
  logic         o_lfsr_valid;
  logic         o_lfsr_one_cycle;
  logic [N-1:0] o_period;
  logic         o_err;

  modport master (
    output i_ena, i_seed_din, i_seed_valid,
    input  o_seed_ready, o_lfsr_dout, o_lfsr_valid, o_lfsr_one_cycle, o_period, o_err
  );

  modport slave (
    input  i_ena, i_seed_din, i_seed_valid,
    output o_seed_ready, o_lfsr_dout, o_lfsr_valid, o_lfsr_one_cycle, o_period, o_err
  );

endinterface

// File: rtl/lfsr_prbs_gen_feedback.sv
// Combinational XNOR feedback for a Fibonacci LFSR: chains the tapped
// register bits through XNOR gates. The all-ones state maps to itself.
module lfsr_feedback #(
  parameter int N = 8
) (
  input  logic [N-1:0] lfsr,
  input  logic [N-1:0] taps,
  output logic         fb
);

  // XNOR chain over the tapped bits, lowest tap first
  always_comb begin
    logic first;
    fb    = 1'b0;
    first = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (taps[i]) begin
        if (first) begin
          fb    = lfsr[i];
          first = 1'b0;
        end else begin
          fb = ~(fb ^ lfsr[i]);
        end
      end
    end
  end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// XNOR Fibonacci LFSR/PRBS generator with seed handshake, lock-up seed
// rejection and measured-period output.
// Build option: LFSR_LOCKUP_RECOVER_EN replaces an all-ones seed with
// all-zeros instead of entering S_FAULT.
//
// state   | meaning
// S_IDLE  | out of reset, waiting for a first seed, no stepping
// S_RUN   | live sequence, steps on i_ena
// S_FAULT | lock-up seed offered, holding with o_err set
module lfsr_prbs_gen
  import lfsr_pkg::*;
#(
  parameter int N = 8
) (
  input logic            i_clk,
  input logic            i_rst,
  lfsr_prbs_gen_if.slave bus
);

  if (N < LFSR_MIN_N || N > LFSR_MAX_N) begin : g_bad_width
    $error("lfsr_prbs_gen: N must be within 3..16");
  end

  localparam logic [15:0]  TAPS_ALL = lfsr_taps(N);
  localparam logic [N-1:0] TAPS     = TAPS_ALL[N-1:0];

  logic [1:0]   state_q;
  logic [N-1:0] lfsr_q;
  logic [N-1:0] seed_q;
  logic [N-1:0] cnt_q;
  logic [N-1:0] period_q;
  logic         valid_q;
  logic         pulse_q;
  logic         err_q;
  logic         ready_q;

  logic         fb;
  logic [N-1:0] lfsr_next;
  logic         seed_acc;
  logic         seed_lockup;
  logic [N-1:0] seed_eff;

  lfsr_feedback #(.N(N)) u_feedback (
    .lfsr (lfsr_q),
    .taps (TAPS),
    .fb   (fb)
  );

  assign lfsr_next = {lfsr_q[N-2:0], fb};
  assign seed_acc  = bus.i_seed_valid & ready_q;

`ifdef LFSR_LOCKUP_RECOVER_EN
  // All-ones is swapped for all-zeros so the lock-up state never loads
  assign seed_lockup = 1'b0;
  assign seed_eff    = (&bus.i_seed_din) ? '0 : bus.i_seed_din;
`else
  assign seed_lockup = &bus.i_seed_din;
  assign seed_eff    = bus.i_seed_din;
`endif

  // Seed load, stepping, wrap detection and FSM transitions
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      lfsr_q   <= '0;
      seed_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      pulse_q  <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      pulse_q <= 1'b0;
      if (seed_acc) begin
        if (seed_lockup) begin
          state_q <= S_FAULT;
          valid_q <= 1'b0;
          err_q   <= 1'b1;
        end else begin
          state_q <= S_RUN;
          lfsr_q  <= seed_eff;
          seed_q  <= seed_eff;
          cnt_q   <= '0;
          valid_q <= 1'b1;
          err_q   <= 1'b0;
        end
      end else if (state_q == S_RUN && bus.i_ena) begin
        lfsr_q <= lfsr_next;
        if (lfsr_next == seed_q) begin
          pulse_q  <= 1'b1;
          period_q <= cnt_q + 1'b1;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.o_seed_ready     = ready_q;
  assign bus.o_lfsr_dout      = lfsr_q;
  assign bus.o_lfsr_valid     = valid_q;
  assign bus.o_lfsr_one_cycle = pulse_q;
  assign bus.o_period         = period_q;
  assign bus.o_err            = err_q;

endmodule
